// File: rtl/apb_initiator.sv
// APB requester: turns single-beat load/store requests into APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout abort is enabled by defining APB_INIT_TIMEOUT_EN.
module apb_initiator #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pdata,
    output logic                    pwrite,
    output logic [DATA_WIDTH/8-1:0] pstb,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    perr,
    output logic                    timeout
);

    localparam int unsigned STB_W = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("apb_initiator: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic [STB_W-1:0]        pstb_q, pstb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef APB_INIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pdata_d     = pdata_q;
        pstb_d      = pstb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {DATA_WIDTH{1'b0}};
`ifdef APB_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pdata_d   = req_wdata;
                    pwrite_d  = req_write;
                    pstb_d    = req_wstb & {STB_W{req_write}};
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_INIT_TIMEOUT_EN
                cnt_d     = {CNT_W{1'b0}};
`endif
            end
            ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = perr;
                    rsp_rdata_d = (!pwrite_q && !perr) ? prdata : {DATA_WIDTH{1'b0}};
                end
`ifdef APB_INIT_TIMEOUT_EN
                // Limit reached with the slave still stalling: abort as an error
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_WIDTH{1'b0}};
            pdata_q     <= {DATA_WIDTH{1'b0}};
            pstb_q      <= {STB_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
`ifdef APB_INIT_TIMEOUT_EN
            cnt_q       <= {CNT_W{1'b0}};
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pdata_q     <= pdata_d;
            pstb_q      <= pstb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE) & presetn;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign pstb      = pstb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_INIT_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_initiator.sv
// Directed self-checking bench for apb_initiator; cycle cN is sampled 1 time unit after
// the Nth rising edge following request acceptance.
module tb_apb_initiator;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pdata;
    logic        pwrite, psel, penable;
    logic [3:0]  pstb;
    logic [31:0] prdata;
    logic        pready, perr, timeout;

    int checks = 0;
    int errors = 0;

    apb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstb(req_wstb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .perr(perr), .timeout(timeout)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstb  = s;
    endtask

    initial begin
        presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstb = '0; prdata = '0; pready = 1'b0; perr = 1'b0;

        // Reset state
        #12;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pstb", 64'(pstb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        step();
        presetn = 1'b1;
        step();
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // 1: simple read, zero wait states
        request(1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
        step();
        req_valid = 1'b0;
        chk("t1_c1_psel", 64'(psel), 64'd1);
        chk("t1_c1_penable", 64'(penable), 64'd0);
        chk("t1_c1_paddr", 64'(paddr), 64'h8000_0010);
        chk("t1_c1_pstb", 64'(pstb), 64'd0);
        chk("t1_c1_req_ready", 64'(req_ready), 64'd0);
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        step();
        chk("t1_c2_penable", 64'(penable), 64'd1);
        chk("t1_c2_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        pready = 1'b0; prdata = '0;
        chk("t1_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_c3_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        chk("t1_c3_err", 64'(rsp_err), 64'd0);
        chk("t1_c3_psel", 64'(psel), 64'd0);
        step();
        chk("t1_c4_rsp_valid", 64'(rsp_valid), 64'd0);

        // 2: write with 4 wait states; bus signals stable while stalled
        request(1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001);
        step();
        req_valid = 1'b0; req_addr = 32'h5555_5555; req_wdata = 32'hAAAA_AAAA; req_wstb = 4'hF;
        prdata = 32'h7777_7777;
        chk("t2_c1_pwrite", 64'(pwrite), 64'd1);
        for (int c = 2; c <= 6; c++) begin
            step();
            chk($sformatf("t2_c%0d_psel", c), 64'(psel), 64'd1);
            chk($sformatf("t2_c%0d_penable", c), 64'(penable), 64'd1);
            chk($sformatf("t2_c%0d_bus", c), {paddr, pdata}, 64'h1000_0000_0000_0041);
            chk($sformatf("t2_c%0d_pstb", c), 64'(pstb), 64'd1);
            chk($sformatf("t2_c%0d_rsp_valid", c), 64'(rsp_valid), 64'd0);
            chk($sformatf("t2_c%0d_timeout", c), 64'(timeout), 64'd0);
        end
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("t2_c7_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_c7_rdata", 64'(rsp_rdata), 64'd0);
        chk("t2_c7_err", 64'(rsp_err), 64'd0);
        step();
        chk("t2_c8_rsp_valid", 64'(rsp_valid), 64'd0);

        // 3: decode fault on unmapped address
        request(1'b0, 32'h3000_0000, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        pready = 1'b1; perr = 1'b1; prdata = 32'h0000_1234;
        step();
        step();
        pready = 1'b0; perr = 1'b0; prdata = '0;
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t3_err", 64'(rsp_err), 64'd1);
        chk("t3_rdata", 64'(rsp_rdata), 64'd0);
        step();
        chk("t3_single_pulse", 64'(rsp_valid), 64'd0);
        chk("t3_err_clear", 64'(rsp_err), 64'd0);

        // 4: back-to-back reads with req_valid held high
        request(1'b0, 32'h8000_0020, 32'h0, 4'hF);
        pready = 1'b1;
        step();
        req_addr = 32'h8000_0024;
        prdata = 32'h1111_1111;
        chk("t4_c1_pstb", 64'(pstb), 64'd0);
        step();
        step();
        prdata = 32'h2222_2222;
        chk("t4_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t4_c3_rdata", 64'(rsp_rdata), 64'h1111_1111);
        chk("t4_c3_psel", 64'(psel), 64'd0);
        chk("t4_c3_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("t4_c4_psel", 64'(psel), 64'd1);
        chk("t4_c4_penable", 64'(penable), 64'd0);
        chk("t4_c4_paddr", 64'(paddr), 64'h8000_0024);
        chk("t4_c4_pstb", 64'(pstb), 64'd0);
        chk("t4_c4_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        step();
        pready = 1'b0; prdata = '0;
        chk("t4_c6_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t4_c6_rdata", 64'(rsp_rdata), 64'h2222_2222);
        step();

        // 5: asynchronous reset during ACCESS of a write
        request(1'b1, 32'h2000_0008, 32'h0BAD_0BAD, 4'hF);
        step();
        req_valid = 1'b0;
        step();
        chk("t5_c2_penable", 64'(penable), 64'd1);
        #2 presetn = 1'b0;
        #1;
        chk("t5_async_psel", 64'(psel), 64'd0);
        chk("t5_async_penable", 64'(penable), 64'd0);
        step();
        chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        presetn = 1'b1;
        step();
        chk("t5_no_rsp_after", 64'(rsp_valid), 64'd0);
        chk("t5_ready_after", 64'(req_ready), 64'd1);
        request(1'b0, 32'h8000_0040, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        pready = 1'b1; prdata = 32'hCAFE_F00D;
        step();
        step();
        pready = 1'b0; prdata = '0;
        chk("t5_read_valid", 64'(rsp_valid), 64'd1);
        chk("t5_read_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        chk("t5_read_err", 64'(rsp_err), 64'd0);
        step();

`ifdef APB_INIT_TIMEOUT_EN
        // 6a: timeout abort after 8 stalled ACCESS cycles (c2..c9)
        request(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        prdata = 32'h9999_9999;
        for (int c = 2; c <= 9; c++) begin
            step();
            chk($sformatf("t6a_c%0d_psel", c), 64'(psel), 64'd1);
        end
        step();
        chk("t6a_c10_psel", 64'(psel), 64'd0);
        chk("t6a_c10_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t6a_c10_err", 64'(rsp_err), 64'd1);
        chk("t6a_c10_timeout", 64'(timeout), 64'd1);
        chk("t6a_c10_rdata", 64'(rsp_rdata), 64'd0);
        step();
        chk("t6a_c11_timeout", 64'(timeout), 64'd0);
        chk("t6a_c11_rsp_valid", 64'(rsp_valid), 64'd0);

        // 6b: pready arrives in the 8th ACCESS cycle; normal completion wins
        request(1'b0, 32'h4000_0004, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        for (int c = 2; c <= 9; c++) step();
        pready = 1'b1; prdata = 32'h0000_ABCD;
        step();
        pready = 1'b0;
        chk("t6b_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t6b_err", 64'(rsp_err), 64'd0);
        chk("t6b_timeout", 64'(timeout), 64'd0);
        chk("t6b_rdata", 64'(rsp_rdata), 64'h0000_ABCD);
        step();
`else
        // 6: without the timeout feature ACCESS waits indefinitely
        request(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        for (int c = 2; c <= 21; c++) step();
        chk("t6_long_wait_psel", 64'(psel), 64'd1);
        chk("t6_long_wait_rsp", 64'(rsp_valid), 64'd0);
        chk("t6_long_wait_timeout", 64'(timeout), 64'd0);
        pready = 1'b1; prdata = 32'h0000_ABCD;
        step();
        pready = 1'b0;
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t6_rdata", 64'(rsp_rdata), 64'h0000_ABCD);
        chk("t6_err", 64'(rsp_err), 64'd0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
